// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI memory target with byte-enabled writes, range checking
// and a fixed-latency, in-order {valid, rdata, err} response pipeline.
module obi_mem_responder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    MEM_WORDS       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    GNT_STALL       = 0,
    parameter int                    RVALID_LAT      = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o
);
    localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;

    logic [31:0]           r_mem [MEM_WORDS];
    logic [2:0]            r_stall;
    logic [2:0]            r_out;
    logic [RVALID_LAT-1:0] r_pv;
    logic [RVALID_LAT-1:0] r_pe;
    logic [31:0]           r_pd [RVALID_LAT];
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IW-1:0]         w_idx;
    logic                  w_oor;
    logic                  w_xfer;
    logic [31:0]           w_rdata;

    // Full-width offset: addresses below the base wrap to huge offsets and
    // fail the range test instead of aliasing into storage.
    always_comb begin
        w_off   = addr_i - BASE_ADDR;
        w_idx   = w_off[IW+1:2];
        w_oor   = addr_i < BASE_ADDR || (w_off >> 2) >= ADDR_WIDTH'(MEM_WORDS);
        gnt_o   = !rst_i && req_i && r_stall == 3'(GNT_STALL) && r_out < 3'(MAX_OUTSTANDING);
        w_xfer  = req_i && gnt_o;
        w_rdata = (!we_i && !w_oor) ? r_mem[w_idx] : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall <= '0;
            r_out   <= '0;
            r_pv    <= '0;
            r_pe    <= '0;
            for (int i = 0; i < RVALID_LAT; i++) r_pd[i] <= '0;
        end else begin
            r_stall <= (!req_i || w_xfer) ? 3'd0 :
                       (r_stall == 3'(GNT_STALL) ? r_stall : r_stall + 3'd1);
            r_out   <= r_out + 3'(w_xfer) - 3'(rvalid_o);
            r_pv[0] <= w_xfer;
            r_pe[0] <= w_xfer && w_oor;
            r_pd[0] <= w_xfer ? w_rdata : 32'h0;
            for (int i = 1; i < RVALID_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_xfer && we_i && !w_oor)
            for (int k = 0; k < 4; k++)
                if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end

    assign rvalid_o = r_pv[RVALID_LAT-1];
    assign err_o    = r_pe[RVALID_LAT-1];
    assign rdata_o  = r_pd[RVALID_LAT-1];
endmodule
